conv3x3_filter: RTL and testbench
=================================

Name: conv3x3_filter

Overview:
- Consumer of the 3-row line-buffer stream.
- Each valid cycle it receives one column of 3 vertically adjacent RGB565 pixels.
- It shifts that column into a 3x3 window, applies a kernel chosen from a fixed table of 8, and emits one filtered RGB565 pixel tagged with the window-centre coordinates.
- It sits between the line buffer and the frame-buffer write / display path.

Parameters:
- HRES, 1280, active pixels per line.
- VRES, 720, active lines per frame.
- KERNEL_SIZE, 3, window edge length; fixed at 3, other values unsupported.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  [KERNEL_SIZE-1:0][15:0]  pixel column; [0] is the top (oldest) row, [2] the bottom row.
- hcount_in  input  11  column of data_in.
- vcount_in  input  10  line number of top row data_in[0].
- data_valid_in  input  1  column valid.
- kernel_sel_in  input  3  kernel table index.
- pixel_out  output  16  filtered RGB565 pixel.
- hcount_out  output  11  centre column of output pixel.
- vcount_out  output  10  centre line of output pixel.
- data_valid_out  output  1  output valid.

Behaviour:
- Reset: while rst_in==0, all outputs are 0, window registers are 0, pipeline valids are 0, active kernel index is 0 (identity). Assertion clears these asynchronously. After deassertion, the first output appears only after new valid input.
- Window shifts left by one column only on data_valid_in; it holds otherwise. Columns are left=oldest, right=newest.
- Window centre coordinates:
  - h_c = (hcount_in==0) ? HRES-1 : hcount_in-1.
  - v_c = (vcount_in==VRES-1) ? 0 : vcount_in+1.
- Coordinates are captured with the shift.
- Active kernel: kernel_sel_in is latched only when data_valid_in && hcount_in==0 && vcount_in==0. Mid-frame changes are ignored until the next frame start. The frame-start column itself uses the newly latched kernel.
- Pipeline: 3 stages, fixed latency 3 cycles from data_valid_in to data_valid_out. Stages advance every cycle and valid propagates; there is no backpressure.
  - S1: window/coordinate register.
  - S2: per-channel multiply-accumulate.
  - S3: shift, clamp and pack.
- Arithmetic, per channel R[15:11], G[10:5], B[4:0], each treated as unsigned:
  - acc = sum of coeff(signed 8b) * channel, held in signed 16b. No overflow is possible for table kernels.
  - res = acc >>> shift (arithmetic shift).
  - Clamp to [0, 31] for R/B and [0, 63] for G.
- Edge policy: if h_c==0, h_c==HRES-1, v_c==0 or v_c==VRES-1, pixel_out = unfiltered centre pixel. Latency is the same.
- End-of-line flush: the centre column HRES-1 is only produced when the next column arrives. The last column of the frame emerges with the first valid column of the following frame. This is accepted behaviour.
- Simultaneous latch-and-shift at frame start: the latch takes effect for that same column.

Optional Feature:
- CONV_ABS_EN defined: after the shift, res = |res| before clamping, so Sobel/Laplacian give edge magnitude.
- Undefined: negative results clamp to 0.

Decomposition:
- Package conv_pkg holds:
  - typedef kernel_t {logic signed [7:0] coeff[9]; logic [2:0] shift;}.
  - Constant KERNEL_TABLE[8], coefficients listed row-major:
    - 0 identity: centre 1, shift 0.
    - 1 box: all 1, shift 3.
    - 2 gaussian: 1 2 1 / 2 4 2 / 1 2 1, shift 4.
    - 3 sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0.
    - 4 sobel_x: -1 0 1 / -2 0 2 / -1 0 1, shift 0.
    - 5 sobel_y: the transpose of sobel_x, shift 0.
    - 6 laplacian: 0 1 0 / 1 -4 1 / 0 1 0, shift 0.
    - 7 emboss: -2 -1 0 / -1 1 1 / 0 1 2, shift 0.
  - Channel width constants.
- Sub-module conv_channel_mac: one instance per channel. Takes nine unsigned channel values plus kernel_t; contains registered MAC (S2) and shift/clamp (S3).

Test Plan:
- Flat 0x8410 frame, kernel 2 (gaussian) -> interior pixel_out 0x8410, data_valid_out exactly 3 cycles after each data_valid_in.
- Interior window with centre 0x1234, kernel 0 -> pixel_out 0x1234, hcount_out=hcount_in-1, vcount_out=vcount_in+1.
- Horizontal R ramp (R = column mod 32), kernel 4 (sobel_x) at column 10 -> R=8 interior. Reversed ramp -> R=0 without CONV_ABS_EN, R=8 with it.
- Columns with hcount_in=0 and hcount_in=1 on any kernel -> outputs at h_c=HRES-1 and h_c=0 equal the raw centre pixel.
- kernel_sel_in changes 0->2 at line 100 -> output stays identity until the next hcount_in=0, vcount_in=0 valid column, then gaussian.
- rst_in driven low mid-line with valids in flight -> data_valid_out and pixel_out read 0 before the next clock edge. After release, no output until 3 cycles after the next valid.

Source files
------------

// File: rtl/conv3x3_filter_pkg.sv
// conv_pkg: shared types and constants for the 3x3 RGB565 convolution filter.
//   kernel_t      : nine signed 8-bit coefficients (row-major, index = row*3+col,
//                   row 0 = top, col 0 = left/oldest) plus a right-shift amount.
//   KERNEL_TABLE  : the eight fixed kernels, indexed by kernel_id_e.
//   CH_W / CH_LSB : RGB565 channel widths and bit positions (R, G, B order).
package conv_pkg;

    localparam int NTAPS = 9;
    localparam int ACC_W = 16;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    localparam int CH_W   [3] = '{R_W, G_W, B_W};
    localparam int CH_LSB [3] = '{R_LSB, G_LSB, B_LSB};

    typedef enum logic [2:0] {
        K_IDENTITY  = 3'd0,
        K_BOX       = 3'd1,
        K_GAUSSIAN  = 3'd2,
        K_SHARPEN   = 3'd3,
        K_SOBEL_X   = 3'd4,
        K_SOBEL_Y   = 3'd5,
        K_LAPLACIAN = 3'd6,
        K_EMBOSS    = 3'd7
    } kernel_id_e;

    typedef struct packed {
        logic [NTAPS-1:0][7:0] coeff;   // each element is a two's-complement coefficient
        logic [2:0]            shift;
    } kernel_t;

    function automatic kernel_t mk_kernel(input int c0, input int c1, input int c2,
                                          input int c3, input int c4, input int c5,
                                          input int c6, input int c7, input int c8,
                                          input int sh);
        kernel_t k;
        k.coeff[0] = 8'(c0); k.coeff[1] = 8'(c1); k.coeff[2] = 8'(c2);
        k.coeff[3] = 8'(c3); k.coeff[4] = 8'(c4); k.coeff[5] = 8'(c5);
        k.coeff[6] = 8'(c6); k.coeff[7] = 8'(c7); k.coeff[8] = 8'(c8);
        k.shift    = 3'(sh);
        return k;
    endfunction

    localparam kernel_t KERNEL_TABLE [8] = '{
        mk_kernel( 0,  0,  0,   0,  1,  0,   0,  0,  0,  0),  // identity
        mk_kernel( 1,  1,  1,   1,  1,  1,   1,  1,  1,  3),  // box
        mk_kernel( 1,  2,  1,   2,  4,  2,   1,  2,  1,  4),  // gaussian
        mk_kernel( 0, -1,  0,  -1,  5, -1,   0, -1,  0,  0),  // sharpen
        mk_kernel(-1,  0,  1,  -2,  0,  2,  -1,  0,  1,  0),  // sobel_x
        mk_kernel(-1, -2, -1,   0,  0,  0,   1,  2,  1,  0),  // sobel_y
        mk_kernel( 0,  1,  0,   1, -4,  1,   0,  1,  0,  0),  // laplacian
        mk_kernel(-2, -1,  0,  -1,  1,  1,   0,  1,  2,  0)   // emboss
    };

endpackage

// File: rtl/conv3x3_filter_if.sv
// Stream interfaces for the 3x3 convolution filter.
//   conv_col_if : incoming pixel columns from the 3-row line buffer
//                 (data_in[0] = top row, hcount/vcount of the column, valid,
//                 kernel select). master = line buffer, slave = filter.
//   conv_pix_if : outgoing filtered pixels with window-centre coordinates.
//                 master = filter, slave = frame-buffer / display path.
interface conv_col_if #(
    parameter int KERNEL_SIZE = 3
);
    logic [KERNEL_SIZE-1:0][15:0] data_in;
    logic [10:0]                  hcount_in;
    logic [9:0]                   vcount_in;
    logic                         data_valid_in;
    logic [2:0]                   kernel_sel_in;

    modport master (output data_in, hcount_in, vcount_in, data_valid_in, kernel_sel_in);
    modport slave  (input  data_in, hcount_in, vcount_in, data_valid_in, kernel_sel_in);
endinterface

interface conv_pix_if;
    logic [15:0] pixel_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;

    modport master (output pixel_out, hcount_out, vcount_out, data_valid_out);
    modport slave  (input  pixel_out, hcount_out, vcount_out, data_valid_out);
endinterface

// File: rtl/conv3x3_filter_channel_mac.sv
// conv_channel_mac: one colour channel of the 3x3 filter.
//   S2: signed multiply-accumulate of nine unsigned channel taps.
//   S3: arithmetic shift, optional magnitude, clamp to [0, 2^W-1]; edge
//       windows bypass to the raw centre tap.
// Ports: clk, rst_n (async active-low), pix_in[9] taps, kern_in kernel,
//        bypass_in edge flag, chan_out registered channel result.
// Optional build macro CONV_ABS_EN: take |res| before clamping so gradient
// kernels report edge magnitude instead of clamping negatives to zero.
module conv_channel_mac
    import conv_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pix_in [NTAPS],
    input  kernel_t      kern_in,
    input  logic         bypass_in,
    output logic [W-1:0] chan_out
);

    localparam logic signed [ACC_W-1:0] CH_MAX = ACC_W'((1 << W) - 1);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              shift_q, shift_d;
    logic                    bypass_q, bypass_d;
    logic [W-1:0]            centre_q, centre_d;
    logic [W-1:0]            chan_q, chan_d;
    logic signed [ACC_W-1:0] res;

    // S2: table kernels cannot overflow 16 bits for 6-bit unsigned taps.
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < NTAPS; i++) begin
            acc_d = acc_d + ACC_W'($signed(kern_in.coeff[i])) * $signed(ACC_W'(pix_in[i]));
        end
        shift_d  = kern_in.shift;
        bypass_d = bypass_in;
        centre_d = pix_in[4];
    end

    // S3
    always_comb begin
        res = acc_q >>> shift_q;
`ifdef CONV_ABS_EN
        if (res < 0) begin
            res = -res;
        end
`endif
        if (bypass_q) begin
            chan_d = centre_q;
        end else if (res < 0) begin
            chan_d = '0;
        end else if (res > CH_MAX) begin
            chan_d = CH_MAX[W-1:0];
        end else begin
            chan_d = res[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            shift_q  <= '0;
            bypass_q <= 1'b0;
            centre_q <= '0;
            chan_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            shift_q  <= shift_d;
            bypass_q <= bypass_d;
            centre_q <= centre_d;
            chan_q   <= chan_d;
        end
    end

    assign chan_out = chan_q;

endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 RGB565 convolution on a column stream from a 3-row
// line buffer. Each valid column shifts into a 3x3 window (S1); each channel
// is multiplied/accumulated (S2) and shifted/clamped (S3). Fixed latency of
// 3 cycles, no backpressure. Border windows pass the raw centre pixel.
// Ports: clk_in, rst_in (async active-low), col_if (conv_col_if.slave input
//        columns + kernel select), pix_if (conv_pix_if.master filtered output).
// Optional build macro CONV_ABS_EN (see conv_channel_mac).
module conv3x3_filter
    import conv_pkg::*;
#(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int KERNEL_SIZE = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    conv_col_if.slave   col_if,
    conv_pix_if.master  pix_if
);

    // Window indexed [row][col]; col 0 = oldest (left), col 2 = newest (right).
    logic [15:0] win_q [KERNEL_SIZE][KERNEL_SIZE];
    logic [15:0] win_d [KERNEL_SIZE][KERNEL_SIZE];

    kernel_id_e  kernel_idx_q, kernel_idx_d;   // frame-latched kernel
    kernel_id_e  kern1_q, kern1_d;             // kernel travelling with S1 window
    logic [10:0] hc1_q, hc1_d, hc2_q, hc2_d, hc3_q, hc3_d;
    logic [9:0]  vc1_q, vc1_d, vc2_q, vc2_d, vc3_q, vc3_d;
    logic        valid1_q, valid1_d, valid2_q, valid2_d, valid3_q, valid3_d;
    logic        frame_start;
    logic        edge1;
    kernel_t     kern_s1;
    logic [15:0] chan_word [3];

    assign frame_start = col_if.data_valid_in && (col_if.hcount_in == '0) && (col_if.vcount_in == '0);

    always_comb begin
        win_d        = win_q;
        kernel_idx_d = kernel_idx_q;
        kern1_d      = kern1_q;
        hc1_d        = hc1_q;
        vc1_d        = vc1_q;

        // The frame-start column itself must already see the new kernel.
        if (frame_start) begin
            kernel_idx_d = kernel_id_e'(col_if.kernel_sel_in);
        end

        if (col_if.data_valid_in) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL_SIZE-1] = col_if.data_in[r];
            end
            kern1_d = kernel_idx_d;
            // Centre is one column behind (wrapping to the previous line's
            // last column) and one line below the top row (wrapping to 0).
            hc1_d = (col_if.hcount_in == '0) ? 11'(HRES - 1) : col_if.hcount_in - 11'd1;
            vc1_d = (col_if.vcount_in == 10'(VRES - 1)) ? '0 : col_if.vcount_in + 10'd1;
        end

        valid1_d = col_if.data_valid_in;
        valid2_d = valid1_q;
        valid3_d = valid2_q;
        hc2_d    = hc1_q;
        vc2_d    = vc1_q;
        hc3_d    = hc2_q;
        vc3_d    = vc2_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            kernel_idx_q <= K_IDENTITY;
            kern1_q      <= K_IDENTITY;
            hc1_q        <= '0;
            vc1_q        <= '0;
            hc2_q        <= '0;
            vc2_q        <= '0;
            hc3_q        <= '0;
            vc3_q        <= '0;
            valid1_q     <= 1'b0;
            valid2_q     <= 1'b0;
            valid3_q     <= 1'b0;
        end else begin
            win_q        <= win_d;
            kernel_idx_q <= kernel_idx_d;
            kern1_q      <= kern1_d;
            hc1_q        <= hc1_d;
            vc1_q        <= vc1_d;
            hc2_q        <= hc2_d;
            vc2_q        <= vc2_d;
            hc3_q        <= hc3_d;
            vc3_q        <= vc3_d;
            valid1_q     <= valid1_d;
            valid2_q     <= valid2_d;
            valid3_q     <= valid3_d;
        end
    end

    assign kern_s1 = KERNEL_TABLE[kern1_q];
    assign edge1   = (hc1_q == '0) || (hc1_q == 11'(HRES - 1)) ||
                     (vc1_q == '0) || (vc1_q == 10'(VRES - 1));

    genvar gi, gt;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            localparam int W = CH_W[gi];
            localparam int L = CH_LSB[gi];
            logic [W-1:0] taps [NTAPS];
            logic [W-1:0] chan;

            for (gt = 0; gt < NTAPS; gt++) begin : g_tap
                assign taps[gt] = win_q[gt / KERNEL_SIZE][gt % KERNEL_SIZE][L +: W];
            end

            conv_channel_mac #(.W(W)) u_mac (
                .clk       (clk_in),
                .rst_n     (rst_in),
                .pix_in    (taps),
                .kern_in   (kern_s1),
                .bypass_in (edge1),
                .chan_out  (chan)
            );

            assign chan_word[gi] = 16'(chan) << L;
        end
    endgenerate

    assign pix_if.pixel_out      = chan_word[0] | chan_word[1] | chan_word[2];
    assign pix_if.hcount_out     = hc3_q;
    assign pix_if.vcount_out     = vc3_q;
    assign pix_if.data_valid_out = valid3_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Self-checking bench for conv3x3_filter: table-driven windows with
// hand-derived results, hand sequences for border columns, kernel latching
// and mid-line reset, and a reference-model scoreboard for every output.
module tb_conv3x3_filter;

    localparam int HRES = 1280;
    localparam int VRES = 720;

`ifdef CONV_ABS_EN
    localparam logic [15:0] REV_RAMP_EXP = 16'h4000;
    localparam logic [15:0] LAP_PT_EXP   = 16'hFFFF;
`else
    localparam logic [15:0] REV_RAMP_EXP = 16'h0000;
    localparam logic [15:0] LAP_PT_EXP   = 16'h0000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_col_if #(.KERNEL_SIZE(3)) col_if ();
    conv_pix_if                    pix_if ();

    conv3x3_filter #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(3)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .col_if (col_if),
        .pix_if (pix_if)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference kernels, row-major.
    int KT [8][9] = '{
        '{ 0,  0,  0,   0,  1,  0,   0,  0,  0},
        '{ 1,  1,  1,   1,  1,  1,   1,  1,  1},
        '{ 1,  2,  1,   2,  4,  2,   1,  2,  1},
        '{ 0, -1,  0,  -1,  5, -1,   0, -1,  0},
        '{-1,  0,  1,  -2,  0,  2,  -1,  0,  1},
        '{-1, -2, -1,   0,  0,  0,   1,  2,  1},
        '{ 0,  1,  0,   1, -4,  1,   0,  1,  0},
        '{-2, -1,  0,  -1,  1,  1,   0,  1,  2}
    };
    int KSH [8] = '{0, 3, 4, 0, 0, 0, 0, 0};

    logic [15:0] mwin [3][3];
    int          mk;

    function automatic logic [15:0] model_pix(input int k, input int hc, input int vc);
        int w, l, acc, res, px;
        logic [15:0] out;
        if (hc == 0 || hc == HRES - 1 || vc == 0 || vc == VRES - 1) return mwin[1][1];
        out = '0;
        for (int ch = 0; ch < 3; ch++) begin
            w = (ch == 1) ? 6 : 5;
            l = (ch == 0) ? 11 : (ch == 1) ? 5 : 0;
            acc = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    px  = int'(mwin[r][c]);
                    acc = acc + KT[k][r*3+c] * ((px >> l) & ((1 << w) - 1));
                end
            res = acc >>> KSH[k];
`ifdef CONV_ABS_EN
            if (res < 0) res = -res;
`endif
            if (res < 0) res = 0;
            if (res > (1 << w) - 1) res = (1 << w) - 1;
            out = out | 16'(res << l);
        end
        return out;
    endfunction

    typedef struct {
        logic [15:0] pix;
        int          h;
        int          v;
        int          cyc;
    } exp_t;
    exp_t sbq [$];

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            col_if.data_valid_in = 1'b0;
        end
    endtask

    task automatic drive_col(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                             input int h, input int v, input int sel,
                             input bit ovr, input logic [15:0] opix, input int oh, input int ov);
        exp_t e;
        int hc, vc;
        @(posedge clk); #1;
        col_if.data_in[0]     = d0;
        col_if.data_in[1]     = d1;
        col_if.data_in[2]     = d2;
        col_if.hcount_in      = 11'(h);
        col_if.vcount_in      = 10'(v);
        col_if.kernel_sel_in  = 3'(sel);
        col_if.data_valid_in  = 1'b1;
        if (h == 0 && v == 0) mk = sel;
        for (int r = 0; r < 3; r++) begin
            mwin[r][0] = mwin[r][1];
            mwin[r][1] = mwin[r][2];
        end
        mwin[0][2] = d0; mwin[1][2] = d1; mwin[2][2] = d2;
        hc = (h == 0) ? HRES - 1 : h - 1;
        vc = (v == VRES - 1) ? 0 : v + 1;
        e.pix = ovr ? opix : model_pix(mk, hc, vc);
        e.h   = ovr ? oh : hc;
        e.v   = ovr ? ov : vc;
        e.cyc = cyc;
        sbq.push_back(e);
    endtask

    function automatic logic [15:0] pat_pix(input int p, input int col, input int row, input int ctr);
        case (p)
            0: return 16'h8410;
            1: return (row == 1) ? 16'h1234 : 16'($urandom);
            2: return 16'((col % 32) << 11);
            3: return 16'((31 - col % 32) << 11);
            default: return (row == 1 && col == ctr) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Output monitor / scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && pix_if.data_valid_out) begin
            $display("out h=%0d v=%0d pix=%04h", pix_if.hcount_out, pix_if.vcount_out, pix_if.pixel_out);
            if (sbq.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("pixel", pix_if.pixel_out, e.pix);
                check("coords", longint'(pix_if.hcount_out) * 1024 + pix_if.vcount_out,
                      longint'(e.h) * 1024 + e.v);
                check("latency", cyc - e.cyc, 3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          kern;
        int          pat;
        int          h;
        int          v;
        logic [15:0] exp_pix;
        int          exp_h;
        int          exp_v;
    } vec_t;
    localparam int NV = 14;
    vec_t vt [NV];

    initial begin
        logic [15:0] d [3];
        logic [15:0] raw_a, raw_b;

        vt[0]  = '{2, 0, 12,  50, 16'h8410, 11,  51};   // gaussian on flat
        vt[1]  = '{0, 1, 21, 200, 16'h1234, 20, 201};   // identity, centre 0x1234
        vt[2]  = '{4, 2, 11,  60, 16'h4000, 10,  61};   // sobel_x on R ramp
        vt[3]  = '{4, 3, 11,  60, REV_RAMP_EXP, 10, 61};// sobel_x on reversed ramp
        vt[4]  = '{1, 0, 40,  70, 16'h9492, 39,  71};   // box on flat
        vt[5]  = '{3, 0, 40,  70, 16'h8410, 39,  71};   // sharpen on flat
        vt[6]  = '{6, 0, 40,  70, 16'h0000, 39,  71};   // laplacian on flat
        vt[7]  = '{7, 0, 40,  70, 16'h8410, 39,  71};   // emboss on flat
        vt[8]  = '{5, 0, 40,  70, 16'h0000, 39,  71};   // sobel_y on flat
        vt[9]  = '{2, 2, 11,  60, 16'h5000, 10,  61};   // gaussian on ramp
        vt[10] = '{3, 4, 80,  90, 16'hFFFF, 79,  91};   // sharpen point, clamps high
        vt[11] = '{6, 4, 80,  90, LAP_PT_EXP, 79, 91};  // laplacian point, negative
        vt[12] = '{1, 1, 30, VRES-2, 16'h1234, 29, VRES-1}; // bottom border
        vt[13] = '{4, 1, 30, VRES-1, 16'h1234, 29, 0};  // top border (wrap)

        col_if.data_in       = '0;
        col_if.hcount_in     = '0;
        col_if.vcount_in     = '0;
        col_if.data_valid_in = 1'b0;
        col_if.kernel_sel_in = '0;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mwin[r][c] = '0;
        mk = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid",  pix_if.data_valid_out, 0);
        check("rst_pixel",  pix_if.pixel_out, 0);
        check("rst_hcount", pix_if.hcount_out, 0);
        check("rst_vcount", pix_if.vcount_out, 0);
        @(negedge clk) rst_n = 1'b1;

        // Table-driven windows: latch kernel at frame start, then 3 columns.
        for (int t = 0; t < NV; t++) begin
            idle(2);
            drive_col(16'h0, 16'h0, 16'h0, 0, 0, vt[t].kern, 1'b0, 16'h0, 0, 0);
            for (int c = vt[t].h - 2; c <= vt[t].h; c++) begin
                idle($urandom_range(0, 1));
                for (int r = 0; r < 3; r++) d[r] = pat_pix(vt[t].pat, c, r, vt[t].h - 1);
                drive_col(d[0], d[1], d[2], c, vt[t].v, $urandom_range(0, 7),
                          c == vt[t].h, vt[t].exp_pix, vt[t].exp_h, vt[t].exp_v);
            end
        end

        // Line wrap: columns hcount 0 and 1 emit raw centres at h_c=HRES-1 and 0.
        idle(2);
        drive_col(16'h0, 16'h0, 16'h0, 0, 0, 2, 1'b0, 16'h0, 0, 0);
        drive_col(16'($urandom), 16'($urandom), 16'($urandom), HRES-2, 300, 1, 1'b0, 16'h0, 0, 0);
        raw_a = 16'($urandom);
        drive_col(16'($urandom), raw_a, 16'($urandom), HRES-1, 300, 3, 1'b0, 16'h0, 0, 0);
        raw_b = 16'($urandom);
        drive_col(16'($urandom), raw_b, 16'($urandom), 0, 301, 4, 1'b1, raw_a, HRES-1, 302);
        drive_col(16'($urandom), 16'($urandom), 16'($urandom), 1, 301, 5, 1'b1, raw_b, 0, 302);
        drive_col(16'($urandom), 16'($urandom), 16'($urandom), 2, 301, 6, 1'b0, 16'h0, 0, 0);

        // Kernel change mid-frame is ignored until next frame start.
        idle(2);
        drive_col(16'h0, 16'h0, 16'h0, 0, 0, 0, 1'b0, 16'h0, 0, 0);
        for (int c = 9; c <= 11; c++) begin
            for (int r = 0; r < 3; r++) d[r] = pat_pix(4, c, r, 10);
            drive_col(d[0], d[1], d[2], c, 100, 2, c == 11, 16'hFFFF, 10, 101);
        end
        idle(1);
        drive_col(16'h0, 16'h0, 16'h0, 0, 0, 2, 1'b0, 16'h0, 0, 0);
        for (int c = 9; c <= 11; c++) begin
            for (int r = 0; r < 3; r++) d[r] = pat_pix(4, c, r, 10);
            drive_col(d[0], d[1], d[2], c, 100, 0, c == 11, 16'h39E7, 10, 101);
        end

        // Asynchronous reset mid-line with valids in flight.
        idle(3);
        for (int c = 500; c < 504; c++)
            drive_col(16'($urandom), 16'($urandom), 16'($urandom), c, 400, 7, 1'b0, 16'h0, 0, 0);
        check("pre_reset_valid", pix_if.data_valid_out, 1);
        #1;
        rst_n = 1'b0;
        col_if.data_valid_in = 1'b0;
        #1;
        check("async_rst_valid",  pix_if.data_valid_out, 0);
        check("async_rst_pixel",  pix_if.pixel_out, 0);
        check("async_rst_hcount", pix_if.hcount_out, 0);
        sbq.delete();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mwin[r][c] = '0;
        mk = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(5);
        for (int c = 600; c < 603; c++)
            drive_col(16'($urandom), 16'($urandom), 16'($urandom), c, 400, 3, 1'b0, 16'h0, 0, 0);

        idle(8);
        check("queue_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
